// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: state encoding and baud timing shared by the UART receiver
// (and a future transmitter).
//   uart_state_t / ST_*   receiver FSM state encoding
//   calc_div(clk, baud)   clock cycles per bit (integer floor)
//   calc_half(div)        clock cycles to the middle of the start bit
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    function automatic int unsigned calc_div(input int unsigned clock_hz,
                                             input int unsigned baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic int unsigned calc_half(input int unsigned div);
        return div / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// sync_2ff: two-flop synchronizer for asynchronous inputs.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both stages load RESET_VALUE
//   d      asynchronous input
//   q      synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver with a one-byte holding register.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high, LSB first
//   data       received byte, stable while valid is high
//   valid      holding register full
//   ready      consumer takes the byte when valid && ready on a rising edge
//   frame_err  one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun    one-cycle pulse, finished byte dropped because holding register full
//
// state | meaning
// IDLE  | waiting for rx_s low (only once re-armed by rx_s high)
// START | counting to mid start bit, rejects glitches
// DATA  | sampling 8 data bits at mid-bit
// STOP  | sampling the stop bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV   = calc_div(CLOCK_HZ, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(DIV);
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic             rx_s;
    uart_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    // Cleared by a framing error so a held-low line (break) produces one
    // frame_err only; set again once the line is seen high in IDLE.
    logic             armed;
    logic             byte_done;
    logic             stop_bad;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign byte_done = (state == ST_STOP) && (cnt == DIV_LAST) &&  rx_s;
    assign stop_bad  = (state == ST_STOP) && (cnt == DIV_LAST) && !rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            armed <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rx_s) begin
                            armed <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Holding register: independent of the receiver FSM so back-pressure
    // never stalls sampling; a byte finishing into a full register is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port data  output  8  received byte, held stable while valid=1.
REQ-007 SHALL have port valid  output  1  byte available in the holding register.
REQ-008 SHALL have port ready  input  1  consumer accepts data when valid&&ready on a rising edge.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped, holding register full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, reset value 1; all decisions use the synchronized value rx_s.
REQ-012 SHALL use DIV = CLOCK_HZ/BAUD_RATE (integer floor; 434 at defaults) and HALF = DIV/2 (217).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-014 IDLE: on rx_s==0 go to START with baud counter cleared to 0.
REQ-015 START: when counter reaches HALF-1, sample rx_s; if 1 (glitch) return to IDLE with no output event; if 0 go to DATA with counter 0, bit index 0.
REQ-016 DATA: each time counter reaches DIV-1, sample rx_s into bit[index], counter to 0, index+1; after index 7 go to STOP.
REQ-017 STOP: when counter reaches DIV-1, sample rx_s; if 1, the byte is complete; if 0, pulse frame_err for one cycle and discard the byte; both cases return to IDLE.
REQ-018 IDLE SHALL NOT re-arm until rx_s==1 has been seen once after a framing error (break condition generates exactly one frame_err).
REQ-019 On byte completion with valid==0, or valid==1&&ready==1 in the same cycle, SHALL load data and set valid=1 on the next edge (no overrun).
REQ-020 On byte completion with valid==1&&ready==0, SHALL keep the old data, keep valid=1, and pulse overrun for one cycle.
REQ-021 valid&&ready with no completion SHALL clear valid on the next edge; data keeps its last value.
REQ-022 Receiver FSM SHALL run independently of ready; back-pressure never stalls sampling.
REQ-023 Latency: valid rises within 2 synchronizer cycles + 1 cycle after the stop-bit sample point.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, counter=0, index=0, synchronizer=1, data=8'h00, valid=0, frame_err=0, overrun=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the next falling edge of rx_s starts a fresh frame.

Structure
REQ-026 SHALL place the FSM state enumeration and the DIV/HALF derivation in shared package uart_pkg for reuse by a future uart_tx.
REQ-027 SHALL contain one sub-module, sync_2ff (parameterized width, reset value), for the rx synchronizer.

Verification
REQ-028 Bench at defaults, bit time 8680 ns: idle 2 bits, frame start,0,1,0,1,0,1,0,1,stop -> data=8'hAA, valid=1, frame_err=0.
REQ-029 Low glitch on rx of 2000 ns (< half bit) -> no valid, no frame_err, FSM back in IDLE.
REQ-030 Frame 8'h3C with stop bit held 0 for 3 bit times -> exactly one frame_err pulse, valid stays 0; next good frame 8'h01 received correctly.
REQ-031 ready=0, send 8'h11 then 8'h22 -> data=8'h11, valid=1, one overrun pulse; then ready=1 one cycle -> valid=0.
REQ-032 ready=1 held, back-to-back frames 8'hFF, 8'h00 -> two valid pulses with those values, no overrun.
REQ-033 rst_n pulsed low during data bit 4 of a frame -> all outputs at reset values; following frame 8'h5A received correctly.
